// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module : ppu_pkg
// Brief  : Shared PPU constants: OAM layout, sprite heights, eval FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

  localparam int OAM2_N = 8;

  // Byte lanes of a 32-bit OAM entry
  localparam int OAM_Y_LSB    = 0;
  localparam int OAM_TILE_LSB = 8;
  localparam int OAM_ATTR_LSB = 16;
  localparam int OAM_X_LSB    = 24;

  localparam logic [7:0] SPR_H8  = 8'd8;
  localparam logic [7:0] SPR_H16 = 8'd16;

  localparam logic [31:0] OAM2_EMPTY = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ppu_spr_range_cmp.sv
`default_nettype none
// ============================================================================
// Module : ppu_spr_range_cmp
// Brief  : Combinational test of whether a sprite at Y covers a scanline.
// Rev    : 1.0 - initial release
// ============================================================================
module ppu_spr_range_cmp
  import ppu_pkg::*;
(
  input  logic [7:0] i_y,
  input  logic [7:0] i_line,
  input  logic       i_spr_16,
  output logic       o_in_range
);

  logic [8:0] w_diff;
  logic [7:0] w_height;

  always_comb begin
    w_diff     = {1'b0, i_line} - {1'b0, i_y};
    w_height   = i_spr_16 ? SPR_H16 : SPR_H8;
    // bit 8 set means the line lies above the sprite top
    o_in_range = !w_diff[8] && (w_diff[7:0] < w_height);
  end

endmodule
`default_nettype wire

// File: rtl/ppu_sprite_eval.sv
`default_nettype none
// ============================================================================
// Module : ppu_sprite_eval
// Brief  : Per-scanline sprite evaluator filling secondary OAM from primary OAM.
// Rev    : 1.0 - initial release
// ============================================================================
module ppu_sprite_eval
  import ppu_pkg::*;
#(
  parameter int OAM_N  = 64,
  parameter int OAM2_N = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_scanline,
  input  logic        i_spr_16,
  output logic [5:0]  o_oam_addr,
  input  logic [31:0] i_oam_q,
  output logic [2:0]  o_oam2_addr,
  output logic [31:0] o_oam2_data,
  output logic        o_oam2_we,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_spr_cnt,
  output logic        o_overflow,
  output logic        o_spr0_in
);

  localparam logic [5:0] c_last_addr = 6'(OAM_N - 1);
  localparam logic [2:0] c_last_clr  = 3'(OAM2_N - 1);
  localparam logic [3:0] c_cnt_full  = 4'(OAM2_N);

  logic [2:0] r_state;
  logic [7:0] r_line;
  logic       r_spr_16;
  logic [5:0] r_addr;
  logic [2:0] r_clr;
  logic [3:0] r_cnt;
  logic       r_ovf;
  logic       r_spr0;

  logic       w_eval;
  logic [5:0] w_eval_idx;
  logic       w_in_range;
  logic       w_hit;
  logic       w_wr;

  ppu_spr_range_cmp u_range (
    .i_y        (i_oam_q[OAM_Y_LSB +: 8]),
    .i_line     (r_line),
    .i_spr_16   (r_spr_16),
    .o_in_range (w_in_range)
  );

  // The read returns one cycle late, so the entry under test is always the
  // previous address; the address wraps to 0 on entering DRAIN, giving 63.
  always_comb begin
    w_eval     = ((r_state == ST_SCAN) && (r_addr != 6'd0)) || (r_state == ST_DRAIN);
    w_eval_idx = r_addr - 6'd1;
    w_hit      = w_eval && w_in_range;
    w_wr       = w_hit && (r_cnt < c_cnt_full);
  end

  always_comb begin
    o_oam2_we   = 1'b0;
    o_oam2_addr = 3'd0;
    o_oam2_data = 32'd0;
    if (r_state == ST_CLEAR) begin
      o_oam2_we   = 1'b1;
      o_oam2_addr = r_clr;
      o_oam2_data = OAM2_EMPTY;
    end else if (w_wr) begin
      o_oam2_we   = 1'b1;
      o_oam2_addr = r_cnt[2:0];
      o_oam2_data = i_oam_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_line   <= 8'd0;
      r_spr_16 <= 1'b0;
      r_addr   <= 6'd0;
      r_clr    <= 3'd0;
      r_cnt    <= 4'd0;
      r_ovf    <= 1'b0;
      r_spr0   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_line   <= i_scanline;
            r_spr_16 <= i_spr_16;
            r_addr   <= 6'd0;
            r_clr    <= 3'd0;
            r_cnt    <= 4'd0;
            r_ovf    <= 1'b0;
            r_spr0   <= 1'b0;
            r_state  <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_clr <= r_clr + 3'd1;
          if (r_clr == c_last_clr) r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          r_addr <= r_addr + 6'd1;
          if (r_addr == c_last_addr) r_state <= ST_DRAIN;
        end
        ST_DRAIN: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      if (w_wr) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_eval_idx == 6'd0) r_spr0 <= 1'b1;
      end else if (w_hit) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_oam_addr = r_addr;
  assign o_busy     = (r_state == ST_CLEAR) || (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign o_done     = (r_state == ST_DONE);
  assign o_spr_cnt  = r_cnt;
  assign o_overflow = r_ovf;
  assign o_spr0_in  = r_spr0;

endmodule
`default_nettype wire

// File: tb/tb_ppu_sprite_eval.sv
`default_nettype none
// ============================================================================
// Module : tb_ppu_sprite_eval
// Brief  : Scoreboard bench for ppu_sprite_eval with a registered-read OAM model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ppu_sprite_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  scanline;
  logic        spr16;
  logic [5:0]  oam_addr;
  logic [31:0] oam_q;
  logic [2:0]  oam2_addr;
  logic [31:0] oam2_data;
  logic        oam2_we;
  logic        busy;
  logic        done;
  logic [3:0]  spr_cnt;
  logic        overflow;
  logic        spr0_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] mem [64];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    int          rel;
  } wr_t;
  wr_t sb[$];

  ppu_sprite_eval dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_scanline  (scanline),
    .i_spr_16    (spr16),
    .o_oam_addr  (oam_addr),
    .i_oam_q     (oam_q),
    .o_oam2_addr (oam2_addr),
    .o_oam2_data (oam2_data),
    .o_oam2_we   (oam2_we),
    .o_busy      (busy),
    .o_done      (done),
    .o_spr_cnt   (spr_cnt),
    .o_overflow  (overflow),
    .o_spr0_in   (spr0_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) oam_q <= mem[oam_addr];

  function automatic bit model_hit(input logic [7:0] y, input logic [7:0] line, input bit s16);
    int d;
    d = int'(line) - int'(y);
    return (d >= 0) && (d < (s16 ? 16 : 8));
  endfunction

  task automatic fill_offscreen();
    for (int k = 0; k < 64; k++) begin
      mem[k] = $urandom();
      mem[k][7:0] = 8'hFF;
    end
  endtask

  // Runs one evaluation; an extra start pulse is driven at cycle extra_start (if >0)
  task automatic run_line(input logic [7:0] line, input bit s16, input int extra_start,
                          input string name);
    int  cnt;
    bit  ovf;
    bit  s0;
    int  t0;
    int  rel;
    bit  done_seen;
    bit  exp_busy;
    wr_t w;
    cnt = 0; ovf = 0; s0 = 0; done_seen = 0;
    sb.delete();
    for (int i = 0; i < 8; i++) sb.push_back('{3'(i), 32'hFFFF_FFFF, 1 + i});
    for (int k = 0; k < 64; k++) begin
      if (model_hit(mem[k][7:0], line, s16)) begin
        if (cnt < 8) begin
          sb.push_back('{3'(cnt), mem[k], 10 + k});
          if (k == 0) s0 = 1;
          cnt++;
        end else begin
          ovf = 1;
        end
      end
    end

    @(negedge clk);
    scanline = line;
    spr16    = s16;
    start    = 1'b1;
    t0       = cyc;
    for (int n = 1; n <= 90 && !done_seen; n++) begin
      @(negedge clk);
      start = (extra_start == n);
      if (extra_start == n) begin
        scanline = ~line;
        spr16    = ~s16;
      end
      rel = cyc - t0;
      exp_busy = (rel >= 1) && (rel <= 73);
      n_tests++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL %s busy at cycle %0d: got %b want %b", name, rel, busy, exp_busy);
      end
      if (oam2_we === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected write at cycle %0d addr %0d data %h", name, rel,
                   oam2_addr, oam2_data);
        end else begin
          w = sb.pop_front();
          if (oam2_addr !== w.addr || oam2_data !== w.data || rel != w.rel) begin
            n_fail++;
            $display("FAIL %s write: got addr %0d data %h cycle %0d, want addr %0d data %h cycle %0d",
                     name, oam2_addr, oam2_data, rel, w.addr, w.data, w.rel);
          end
        end
      end
      if (done === 1'b1) begin
        done_seen = 1;
        n_tests++;
        if (rel != 74) begin
          n_fail++;
          $display("FAIL %s done cycle: got %0d want 74", name, rel);
        end
      end
    end
    start = 1'b0;

    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen within 90 cycles, want cycle 74", name);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing writes: got %0d outstanding want 0", name, sb.size());
    end
    n_tests++;
    if (spr_cnt !== 4'(cnt) || overflow !== ovf || spr0_in !== s0) begin
      n_fail++;
      $display("FAIL %s results: got cnt %0d ovf %b spr0 %b, want cnt %0d ovf %b spr0 %b",
               name, spr_cnt, overflow, spr0_in, cnt, ovf, s0);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if (oam_addr !== 6'd0 || oam2_addr !== 3'd0 || oam2_data !== 32'd0 || oam2_we !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || spr_cnt !== 4'd0 || overflow !== 1'b0 ||
        spr0_in !== 1'b0) begin
      n_fail++;
      $display("FAIL %s outputs: got addr %0d a2 %0d d2 %h we %b busy %b done %b cnt %0d ovf %b s0 %b, want all 0",
               name, oam_addr, oam2_addr, oam2_data, oam2_we, busy, done, spr_cnt, overflow,
               spr0_in);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_empty();
    fill_offscreen();
    run_line(8'd100, 1'b0, 0, "empty");
  endtask

  task automatic test_three();
    fill_offscreen();
    mem[3][7:0]  = 8'd96;
    mem[10][7:0] = 8'd96;
    mem[40][7:0] = 8'd96;
    run_line(8'd100, 1'b0, 0, "three");
  endtask

  task automatic test_spr0();
    fill_offscreen();
    mem[0][7:0]  = 8'd100;
    mem[20][7:0] = 8'd99;
    run_line(8'd100, 1'b0, 0, "spr0");
  endtask

  task automatic test_overflow();
    fill_offscreen();
    for (int i = 0; i < 10; i++) mem[2 + 6 * i][7:0] = 8'd50;
    run_line(8'd57, 1'b0, 0, "ovf8x8_in");
    run_line(8'd58, 1'b0, 0, "ovf8x8_out");
    run_line(8'd65, 1'b1, 0, "ovf8x16_in");
    run_line(8'd66, 1'b1, 0, "ovf8x16_out");
  endtask

  task automatic test_boundary();
    fill_offscreen();
    mem[7][7:0] = 8'd240;
    run_line(8'd239, 1'b0, 0, "y240_line239");
    fill_offscreen();
    mem[9][7:0]  = 8'd0;
    mem[30][7:0] = 8'd250;
    run_line(8'd15, 1'b1, 0, "y0_line15_16");
  endtask

  task automatic test_reset_mid();
    int t0;
    fill_offscreen();
    for (int k = 0; k < 6; k++) mem[k][7:0] = 8'd120;
    @(negedge clk);
    scanline = 8'd121;
    spr16    = 1'b0;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid");
    rst = 1'b0;
  endtask

  task automatic test_restart_ignore();
    fill_offscreen();
    mem[1][7:0]  = 8'd10;
    mem[63][7:0] = 8'd12;
    run_line(8'd14, 1'b0, 20, "restart_ignore");
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    scanline = 8'd0;
    spr16    = 1'b0;
    fill_offscreen();
    test_reset();
    test_empty();
    test_three();
    test_spr0();
    test_overflow();
    test_boundary();
    test_reset_mid();
    test_restart_ignore();
    test_three();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
